// File: rtl/ble4_lut4_cfg_if.sv
// ble4_lut4_cfg_if: serial configuration chain bundle for the BLE4 LUT stage.
// The master side (a bitstream loader or the previous tile) drives the load
// request and the serial data; the slave side (the LUT stage) reports load
// status and exposes its shift-register tail for daisy-chaining.
interface ble4_lut4_cfg_if;
    logic cfg_start;
    logic cfg_bit;
    logic cfg_bit_valid;
    logic cfg_busy;
    logic cfg_done;
    logic cfg_err;
    logic ccff_tail;

    modport master (
        output cfg_start,
        output cfg_bit,
        output cfg_bit_valid,
        input  cfg_busy,
        input  cfg_done,
        input  cfg_err,
        input  ccff_tail
    );

    modport slave (
        input  cfg_start,
        input  cfg_bit,
        input  cfg_bit_valid,
        output cfg_busy,
        output cfg_done,
        output cfg_err,
        output ccff_tail
    );
endinterface

// File: rtl/ble4_lut4_cfg.sv
// ble4_lut4_cfg: configurable K-input LUT plus BLE output-mode bit.
// Configuration arrives serially (mode bit first, then truth-table bits from
// the top entry down to entry 0) into a shadow shift register and is copied
// into the live configuration in a single cycle, so the live function never
// shows a partially loaded bitstream.
// Optional feature macro: BLE4_CFG_PARITY_EN -- appends one even-parity bit
// to the bitstream; a failing load leaves the live function untouched and
// raises cfg_err.
module ble4_lut4_cfg #(
    parameter int LUT_K = 4
) (
    input  logic               clk,
    input  logic               reset,
    ble4_lut4_cfg_if.slave     cfg,
    input  logic [LUT_K-1:0]   lut_in,
    output logic               lut_out,
    input  logic               ff_Q,
    output logic               ble_out
);

    localparam int TT = 2 ** LUT_K;       // truth-table entries
    localparam int N  = TT + 1;           // stored chain length: mode + table
`ifdef BLE4_CFG_PARITY_EN
    localparam int L  = N + 1;            // accepted bits per load incl. parity
`else
    localparam int L  = N;                // accepted bits per load
`endif
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(L - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_sr;
    logic [N-1:0]    r_active;
    logic            r_busy;
    logic            r_done;

    logic            w_load_start;
    logic            w_accept;
    logic            w_store_bit;
    logic            w_commit;
    logic            w_reject;
    logic            w_par_fail;
    logic [TT-1:0]   w_table;
    logic            w_mode;

`ifdef BLE4_CFG_PARITY_EN
    logic            r_par;
    logic            r_err;

    // Running even-parity accumulator over every accepted bit.
    function automatic logic f_par_acc(input logic acc, input logic b);
        return acc ^ b;
    endfunction

    // The parity bit is the final accepted bit; it feeds the accumulator
    // only and never enters the shadow register.
    assign w_store_bit = (r_cnt != LAST_IDX);
    assign w_par_fail  = r_par;
`else
    assign w_store_bit = 1'b1;
    assign w_par_fail  = 1'b0;
`endif

    // Next-state and per-cycle load control decode.
    always_comb begin
        w_next_state = r_state;
        w_load_start = 1'b0;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (cfg.cfg_start) begin
                    w_next_state = ST_SHIFT;
                    w_load_start = 1'b1;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_SHIFT: begin
                // cfg_start is deliberately not decoded here: a load in
                // progress cannot be restarted.
                if (cfg.cfg_bit_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        w_next_state = ST_COMMIT;
                    end else begin
                        w_next_state = ST_SHIFT;
                    end
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                if (w_par_fail) begin
                    w_reject     = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_commit     = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Accepted-bit counter: cleared on a new request, stepped per accepted bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_load_start) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Shadow shift register; not cleared on a new request so the tail keeps
    // presenting the chain contents to the downstream tile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr <= '0;
        end else if (w_accept && w_store_bit) begin
            r_sr <= {r_sr[N-2:0], cfg.cfg_bit};
        end else begin
            r_sr <= r_sr;
        end
    end

    // Live configuration: changes only on a successful commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active <= '0;
        end else if (w_commit) begin
            r_active <= r_sr;
        end else begin
            r_active <= r_active;
        end
    end

    // Busy flag, registered from the next state so it rises with the request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_SHIFT) || (w_next_state == ST_COMMIT);
        end
    end

    // Done flag: dropped when a new load starts, raised on a good commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else if (w_load_start) begin
            r_done <= 1'b0;
        end else if (w_commit) begin
            r_done <= 1'b1;
        end else begin
            r_done <= r_done;
        end
    end

`ifdef BLE4_CFG_PARITY_EN
    // Parity accumulator, restarted with every load request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par <= 1'b0;
        end else if (w_load_start) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= f_par_acc(r_par, cfg.cfg_bit);
        end else begin
            r_par <= r_par;
        end
    end

    // Error flag: dropped when a new load starts, raised on a rejected commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_load_start) begin
            r_err <= 1'b0;
        end else if (w_reject) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign cfg.cfg_err = r_err;
`else
    assign cfg.cfg_err = 1'b0;
`endif

    assign cfg.cfg_busy  = r_busy;
    assign cfg.cfg_done  = r_done;
    assign cfg.ccff_tail = r_sr[N-1];

    // The LUT path is combinational so the downstream flip-flop sees the new
    // select inputs in the same cycle.
    assign w_table = r_active[TT-1:0];
    assign w_mode  = r_active[N-1];
    assign lut_out = w_table[lut_in];
    assign ble_out = w_mode ? ff_Q : lut_out;

endmodule

// File: doc/ble4_lut4_cfg.md
# ble4_lut4_cfg

Upstream stage of the BLE4 flip-flop. Holds a K-input LUT and the BLE output-mode bit, both programmed through a serial configuration chain under a small load FSM. `lut_out` drives the flip-flop's `ff_D`. `ble_out` selects between the combinational LUT output and the flip-flop's `ff_Q`. New configuration is shifted into a shadow register and committed atomically, so the live function never shows partial bitstreams.

## Interface
- `LUT_K`, default 4: LUT input count, legal range 2..6. Chain length N = 2^LUT_K + 1 (mode bit plus truth table).

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state while low.
- `cfg_start`  in  1  single-cycle request to begin a load.
- `cfg_bit`  in  1  serial configuration data.
- `cfg_bit_valid`  in  1  `cfg_bit` is valid this cycle.
- `cfg_busy`  out  1  load in progress (SHIFT or COMMIT).
- `cfg_done`  out  1  a valid configuration has been committed.
- `cfg_err`  out  1  parity failure on the last load (only with `BLE4_CFG_PARITY_EN`).
- `ccff_tail`  out  1  shift register MSB, for daisy-chaining the next tile.
- `lut_in`  in  LUT_K  LUT select inputs.
- `lut_out`  out  1  LUT result, feeds the flip-flop `ff_D`.
- `ff_Q`  in  1  flip-flop output returned to this block.
- `ble_out`  out  1  BLE output.

## Operation
Storage:
- `sr`: N-bit shadow shift register.
- `active`: N-bit live configuration. Bit N-1 is the mode bit; bits [2^K-1:0] are the truth table.
- `lut_out = active[lut_in]`.
- `ble_out = active[N-1] ? ff_Q : lut_out`. Purely combinational from `active`, `lut_in` and `ff_Q`.

Serial order: the first accepted bit is the mode bit, followed by truth-table bits 2^K-1 down to 0. On each accepted bit, `sr <= {sr[N-2:0], cfg_bit}` and `cnt` increments.

FSM states: IDLE, SHIFT, COMMIT, DONE.
- **IDLE / DONE**, `cfg_start`=1:
  - go to SHIFT
  - `cnt` <= 0
  - `cfg_done` <= 0
  - `cfg_err` <= 0
- **SHIFT**:
  - A bit is accepted iff `cfg_bit_valid`=1; invalid cycles stall with no shift.
  - When the final bit is accepted (`cnt` = L-1, where L = N, or N+1 with parity), go to COMMIT.
  - `cfg_start` is ignored in this state.
- **COMMIT**:
  - Normal: `active` <= `sr`, go to DONE.
  - Parity failure: `active` unchanged, `cfg_err` <= 1, go to IDLE.
- **DONE**: holds until the next `cfg_start`.

Other behaviour:
- `cfg_bit_valid` is ignored outside SHIFT.
- `cnt` width is clog2(N+1).

## Timing
- Reset (async assert, sync-clean release):
  - state IDLE; `sr`, `active` and `cnt` all 0.
  - `cfg_busy`=0, `cfg_done`=0, `cfg_err`=0, `ccff_tail`=0.
  - `lut_out`=0; `ble_out`=`lut_out`=0.
- `cfg_start` sampled at edge E0: `cfg_busy`=1 from E0; the first bit can be accepted at E0+1.
- Last bit accepted at edge E: state is COMMIT during cycle E..E+1.
- At edge E+1:
  - `active` updates and `lut_out`/`ble_out` reflect the new function.
  - `cfg_done`=1 and `cfg_busy`=0.
- Minimum load time with continuous valid: L+2 cycles from `cfg_start`.
- `lut_out`/`ble_out` have zero latency from `lut_in`/`ff_Q`.
- During SHIFT, `active` (and therefore the live function) is unchanged.
- `ccff_tail` = `sr[N-1]` in every state, and is registered.
- Reset asserted mid-load: immediate return to reset values; the previous `active` is lost (zeroed).

## Configuration
- Macro: `BLE4_CFG_PARITY_EN`.
- **Defined**:
  - One extra bit follows the truth table, so L = N+1.
  - The parity bit is consumed into a running XOR and is not stored in `sr`.
  - The N+1 accepted bits must have even parity; on mismatch, COMMIT takes the error path.
- **Undefined**:
  - L = N; no parity logic is built.
  - `cfg_err` is tied to 0.

## Test plan
- **Reset**: hold `reset`=0 mid-load, then release. Required: all outputs 0, state IDLE; `lut_in`=4'hF gives `lut_out`=0.
- **AND4 load** (no parity): `cfg_start`, then bits 0, then 0x8000 MSB-first, contiguous valid. Required:
  - `cfg_done`=1 exactly 19 cycles after `cfg_start`.
  - `lut_out`=1 only for `lut_in`=F.
  - `ble_out`=`lut_out`.
- **FF mode**: load mode bit 1 with table 0x6996. Required: `ble_out` follows `ff_Q` (toggle 0/1) regardless of `lut_in`; `lut_out`=XOR4 of `lut_in`.
- **Stalls and ignored start**: insert random `cfg_bit_valid`=0 gaps and pulse `cfg_start` mid-SHIFT. Required:
  - Same result as the contiguous load.
  - Old function stays live until COMMIT.
  - `ccff_tail` equals the bit shifted in 16 accepted bits earlier.
- **Parity** (`BLE4_CFG_PARITY_EN`):
  - Load XOR4 with the correct parity bit: `cfg_done`=1, `cfg_err`=0.
  - Repeat with the parity bit flipped: `cfg_err`=1, state IDLE, `active` still XOR4.
